room_model: RTL and testbench

ROOM_MODEL -- requirements
Module: room_model

---
 rtl/room_model_if.sv | 30 +++
 rtl/room_model.sv | 141 ++++++++++++++
 tb/tb_room_model.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/room_model_if.sv
// Controller-side bundle between the AC controller and the room plant model.
// The controller drives the requests and ambient; the room returns its state.
interface room_model_if;
  localparam int unsigned TEMP_W = 5;

  logic              heating;
  logic              cooling;
  logic [TEMP_W-1:0] ambient;
  logic [TEMP_W-1:0] temperature;
  logic              step;
  logic              fault;

  modport master (
    output heating,
    output cooling,
    output ambient,
    input  temperature,
    input  step,
    input  fault
  );

  modport slave (
    input  heating,
    input  cooling,
    input  ambient,
    output temperature,
    output step,
    output fault
  );
endinterface

// File: rtl/room_model.sv
// Thermal plant model: heats, cools or drifts toward ambient one degree per
// prescaler period; conflicting requests park the room in FAULT.
module room_model #(
  parameter int unsigned TICKS       = 10,
  parameter int unsigned DRIFT_TICKS = 40,
  parameter logic [4:0]  INIT_TEMP   = 5'd18
) (
  input  logic         clk,
  input  logic         rst,
  room_model_if.slave  bus
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned TEMP_W = 5;

  localparam logic [CNT_W-1:0]  ACT_LAST   = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0]  DRIFT_LAST = CNT_W'(DRIFT_TICKS - 1);
  localparam logic [TEMP_W-1:0] TEMP_MAX   = TEMP_W'(31);
  localparam logic [TEMP_W-1:0] TEMP_MIN   = TEMP_W'(0);
  localparam logic [TEMP_W-1:0] TEMP_ONE   = TEMP_W'(1);

  typedef enum logic [1:0] {
    DRIFT = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [TEMP_W-1:0]  temp;
  logic [TEMP_W-1:0]  temp_nxt;
  logic               step_q;
  logic               step_nxt;
  logic               fault_q;
  logic               fault_nxt;
  logic               tick_due;

  // Register stage: reset wins over every transition, count and step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DRIFT;
      cnt     <= '0;
      temp    <= INIT_TEMP;
      step_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      temp    <= temp_nxt;
      step_q  <= step_nxt;
      fault_q <= fault_nxt;
    end
  end

  // Next state, prescaler and temperature update.
  always_comb begin
    state_nxt = DRIFT;
    cnt_nxt   = cnt;
    temp_nxt  = temp;
    step_nxt  = 1'b0;
    fault_nxt = 1'b0;
    tick_due  = 1'b0;

    if (bus.heating && bus.cooling) begin
      state_nxt = FAULT;
    end else if (bus.heating) begin
      state_nxt = HEAT;
    end else if (bus.cooling) begin
      state_nxt = COOL;
    end else begin
      state_nxt = DRIFT;
    end

    fault_nxt = (state_nxt == FAULT);

    // A state change throws away any partial count and never steps.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        HEAT, COOL: begin
          if (cnt == ACT_LAST) begin
            cnt_nxt  = '0;
            tick_due = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DRIFT: begin
          if (cnt == DRIFT_LAST) begin
            cnt_nxt  = '0;
            tick_due = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt_nxt = '0;
        end
      endcase
    end

    // Saturating move; step only reports an actual change.
    if (tick_due) begin
      case (state)
        HEAT: begin
          if (temp != TEMP_MAX) begin
            temp_nxt = temp + TEMP_ONE;
            step_nxt = 1'b1;
          end
        end
        COOL: begin
          if (temp != TEMP_MIN) begin
            temp_nxt = temp - TEMP_ONE;
            step_nxt = 1'b1;
          end
        end
        DRIFT: begin
          if (temp < bus.ambient) begin
            temp_nxt = temp + TEMP_ONE;
            step_nxt = 1'b1;
          end else if (temp > bus.ambient) begin
            temp_nxt = temp - TEMP_ONE;
            step_nxt = 1'b1;
          end
        end
        default: begin
          temp_nxt = temp;
        end
      endcase
    end
  end

  assign bus.temperature = temp;
  assign bus.step        = step_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_room_model.sv
// Scoreboarded bench for room_model: a behavioural plant model predicts every
// edge; directed scenarios add fixed-value checks and a closed control loop.
module tb_room_model;

  localparam int unsigned TICKS       = 4;
  localparam int unsigned DRIFT_TICKS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  room_model_if bus ();

  room_model #(
    .TICKS       (TICKS),
    .DRIFT_TICKS (DRIFT_TICKS),
    .INIT_TEMP   (5'd18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {M_DRIFT, M_HEAT, M_COOL, M_FAULT} mstate_t;
  typedef struct {
    int temp;
    int step;
    int fault;
  } exp_t;

  exp_t    sb[$];
  mstate_t m_state = M_DRIFT;
  int      m_phase = 0;
  int      m_temp  = 18;
  int      n_tests = 0;
  int      n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Plant model: phase counts edges spent in the current state.
  function automatic void model_edge(input bit r, input bit h, input bit c, input int amb);
    mstate_t ns;
    int      lim;
    int      moved;
    exp_t    e;
    moved = 0;
    if (r) begin
      m_state = M_DRIFT;
      m_phase = 0;
      m_temp  = 18;
    end else begin
      ns = (h && c) ? M_FAULT : h ? M_HEAT : c ? M_COOL : M_DRIFT;
      if (ns != m_state) begin
        m_state = ns;
        m_phase = 0;
      end else if (m_state != M_FAULT) begin
        lim = (m_state == M_DRIFT) ? int'(DRIFT_TICKS) : int'(TICKS);
        m_phase++;
        if (m_phase == lim) begin
          m_phase = 0;
          if (m_state == M_HEAT && m_temp < 31) begin
            m_temp++;
            moved = 1;
          end else if (m_state == M_COOL && m_temp > 0) begin
            m_temp--;
            moved = 1;
          end else if (m_state == M_DRIFT && m_temp < amb) begin
            m_temp++;
            moved = 1;
          end else if (m_state == M_DRIFT && m_temp > amb) begin
            m_temp--;
            moved = 1;
          end
        end
      end
    end
    e.temp  = m_temp;
    e.step  = moved;
    e.fault = (!r && m_state == M_FAULT) ? 1 : 0;
    sb.push_back(e);
  endfunction

  task automatic cyc(input bit r, input bit h, input bit c, input int amb);
    exp_t e;
    rst         = r;
    bus.heating = h;
    bus.cooling = c;
    bus.ambient = 5'(amb);
    model_edge(r, h, c, amb);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check_eq("sb_temp", int'(bus.temperature), e.temp);
      check_eq("sb_step", int'(bus.step), e.step);
      check_eq("sb_fault", int'(bus.fault), e.fault);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int k;
    int amb;
    bit h;
    bit c;
    bit prev_step;

    bus.heating = 1'b0;
    bus.cooling = 1'b0;
    bus.ambient = 5'd18;
    @(negedge clk);

    // Reset with a heat request present.
    cyc(1, 1, 0, 18);
    check_eq("rst_temp", int'(bus.temperature), 18);
    check_eq("rst_step", int'(bus.step), 0);
    check_eq("rst_fault", int'(bus.fault), 0);

    // Heating: entry edge is i=0, steps at i=4 and i=8.
    for (int i = 0; i <= 8; i++) begin
      cyc(0, 1, 0, 18);
      if (i == 0) check_eq("heat_entry", int'(bus.temperature), 18);
      if (i == 3) check_eq("heat_e3_step", int'(bus.step), 0);
      if (i == 4) begin
        check_eq("heat_e4_temp", int'(bus.temperature), 19);
        check_eq("heat_e4_step", int'(bus.step), 1);
      end
      if (i == 5) check_eq("heat_e5_step", int'(bus.step), 0);
      if (i == 8) begin
        check_eq("heat_e8_temp", int'(bus.temperature), 20);
        check_eq("heat_e8_step", int'(bus.step), 1);
      end
    end

    // Upper saturation.
    k = 0;
    while (bus.temperature != 5'd30 && k < 200) begin
      cyc(0, 1, 0, 18);
      k++;
    end
    check_eq("reach_30", int'(bus.temperature), 30);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 18);
    check_eq("sat_hi_temp", int'(bus.temperature), 31);
    check_eq("sat_hi_step", int'(bus.step), 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 18);
      check_eq("sat_hi_hold", int'(bus.temperature), 31);
      check_eq("sat_hi_nostep", int'(bus.step), 0);
    end

    // Lower saturation.
    k = 0;
    while (bus.temperature != 5'd1 && k < 300) begin
      cyc(0, 0, 1, 18);
      k++;
    end
    check_eq("reach_1", int'(bus.temperature), 1);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 18);
    check_eq("sat_lo_temp", int'(bus.temperature), 0);
    check_eq("sat_lo_step", int'(bus.step), 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 18);
      check_eq("sat_lo_hold", int'(bus.temperature), 0);
      check_eq("sat_lo_nostep", int'(bus.step), 0);
    end

    // Fault: both requests, then release cooling.
    k = 0;
    while (bus.temperature != 5'd10 && k < 100) begin
      cyc(0, 1, 0, 18);
      k++;
    end
    check_eq("reach_10", int'(bus.temperature), 10);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 1, 18);
      check_eq("fault_flag", int'(bus.fault), 1);
      check_eq("fault_temp", int'(bus.temperature), 10);
      check_eq("fault_nostep", int'(bus.step), 0);
    end
    for (int i = 0; i <= 4; i++) begin
      cyc(0, 1, 0, 18);
      check_eq("unfault_flag", int'(bus.fault), 0);
      check_eq("unfault_temp", int'(bus.temperature), (i == 4) ? 11 : 10);
    end

    // Mid-count switch heat -> cool discards progress.
    cyc(0, 1, 0, 18);
    cyc(0, 1, 0, 18);
    for (int i = 0; i <= 4; i++) begin
      cyc(0, 0, 1, 18);
      if (i == 0) check_eq("switch_nostep", int'(bus.step), 0);
      check_eq("switch_temp", int'(bus.temperature), (i == 4) ? 10 : 11);
    end

    // Reset mid-count and while in FAULT.
    cyc(0, 1, 0, 15);
    cyc(0, 1, 1, 15);
    cyc(1, 1, 1, 15);
    check_eq("rst_prio_temp", int'(bus.temperature), 18);
    check_eq("rst_prio_fault", int'(bus.fault), 0);

    // Drift toward ambient 15, then hold, then toward 20.
    for (int i = 1; i <= 24; i++) begin
      cyc(0, 0, 0, 15);
      if (i == 7)  check_eq("drift_e7", int'(bus.temperature), 18);
      if (i == 8)  check_eq("drift_e8", int'(bus.temperature), 17);
      if (i == 16) check_eq("drift_e16", int'(bus.temperature), 16);
      if (i == 24) check_eq("drift_e24", int'(bus.temperature), 15);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 15);
      check_eq("drift_hold", int'(bus.temperature), 15);
      check_eq("drift_hold_step", int'(bus.step), 0);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 20);
    check_eq("drift_rise", int'(bus.temperature), 16);

    // Closed loop with a bang-bang controller and wandering ambient.
    amb = 18;
    prev_step = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) amb = int'($urandom_range(31, 0));
      h = (bus.temperature < 5'd20);
      c = (bus.temperature > 5'd24);
      cyc(0, h, c, amb);
      check_eq("cl_fault", int'(bus.fault), 0);
      check_eq("cl_step_pair", (prev_step && bus.step) ? 1 : 0, 0);
      prev_step = bus.step;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
